// File: rtl/sync_pkg.sv
// sync_pkg: shared default parameters and counter-width helper for the debouncer
// Ports: none (package)
package sync_pkg;
    localparam int N_CH_DEF      = 4;
    localparam int N_STAGES_DEF  = 2;
    localparam int DB_CYCLES_DEF = 16;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/module_sync_debounce_if.sv
// module_sync_debounce_if: bundle of debounce strobe, raw inputs and debounced outputs
// Ports: tick_en, d_in (to debouncer); d_out, rise, fall (from debouncer)
interface module_sync_debounce_if
    import sync_pkg::*;
#(
    parameter int N_CH = N_CH_DEF
);
    logic            tick_en;
    logic [N_CH-1:0] d_in;
    logic [N_CH-1:0] d_out;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;

    modport master (output tick_en, d_in, input d_out, rise, fall);
    modport slave  (input tick_en, d_in, output d_out, rise, fall);
endinterface

// File: rtl/module_debounce_ch.sv
// module_debounce_ch: one-channel synchronizer chain, debounce counter and edge pulses
// Ports: clk, reset (sync, active-high), i_tick_en (qualify strobe), i_d (raw async input),
//        o_d (debounced level), o_rise / o_fall (one-cycle registered edge pulses)
module module_debounce_ch
    import sync_pkg::*;
#(
    parameter int N_STAGES  = N_STAGES_DEF,
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_tick_en,
    input  logic i_d,
    output logic o_d,
    output logic o_rise,
    output logic o_fall
);
    localparam int CW = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    logic [N_STAGES-1:0] r_sync;
    logic [CW-1:0]       r_cnt;
    logic                w_s;
    logic                w_differ;
    logic                w_accept;

    assign w_s      = r_sync[N_STAGES-1];
    assign w_differ = w_s != o_d;
    // Accept on the qualifying cycle that completes the run; the counter therefore never wraps.
    assign w_accept = w_differ && i_tick_en && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_cnt  <= '0;
            o_d    <= 1'b0;
            o_rise <= 1'b0;
            o_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[N_STAGES-2:0], i_d};
            r_cnt  <= (!w_differ || w_accept) ? '0 : i_tick_en ? r_cnt + 1'b1 : r_cnt;
            o_d    <= w_accept ? w_s : o_d;
            o_rise <= w_accept && w_s;
            o_fall <= w_accept && !w_s;
        end
    end
endmodule

// File: rtl/module_sync_debounce.sv
// module_sync_debounce: N_CH independent synchronize-and-debounce channels
// Ports: clk, reset (sync, active-high), bus (slave: tick_en, d_in in; d_out, rise, fall out)
module module_sync_debounce
    import sync_pkg::*;
#(
    parameter int N_CH      = N_CH_DEF,
    parameter int N_STAGES  = N_STAGES_DEF,
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input logic                   clk,
    input logic                   reset,
    module_sync_debounce_if.slave bus
);
    logic [N_CH-1:0] w_d_out;
    logic [N_CH-1:0] w_rise;
    logic [N_CH-1:0] w_fall;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        module_debounce_ch #(
            .N_STAGES (N_STAGES),
            .DB_CYCLES(DB_CYCLES)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .i_tick_en(bus.tick_en),
            .i_d      (bus.d_in[c]),
            .o_d      (w_d_out[c]),
            .o_rise   (w_rise[c]),
            .o_fall   (w_fall[c])
        );
    end

    assign bus.d_out = w_d_out;
    assign bus.rise  = w_rise;
    assign bus.fall  = w_fall;
endmodule
